wb_stage_pipe: RTL and testbench

Registered, parametrised writeback stage for the RISC-V core; the successor to the pass-through writeback stage. Sits between the memory stage and the register file. ALU results retire one cycle after acceptance. Loads are held until the data memory returns its response, then aligned, sign- or zero-extended, and written back. Supports XLEN 32/64, stalls the memory stage via a ready/valid handshake, flushes pending loads, and flags misaligned load accesses.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/load_extract.sv | 32 +++
 rtl/wb_stage_pipe.sv | 123 ++++++++++++
 tb/tb_wb_stage_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, FSM states
// and the load legality/alignment check.
package wb_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t WAIT  = 2'd1;
    localparam state_t DRAIN = 2'd2;

    // True when the load exists for this XLEN and its address is naturally aligned.
    function automatic logic ld_ok(input int unsigned xlen, input logic [2:0] sel,
                                   input logic [2:0] off);
        logic ok;
        ok = 1'b0;
        case (sel)
            LB, LBU: ok = 1'b1;
            LH, LHU: ok = ~off[0];
            LW:      ok = (off[1:0] == 2'b00);
            LWU:     ok = (xlen == 64) && (off[1:0] == 2'b00);
            LD:      ok = (xlen == 64) && (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word/dword of a read word and extends it
// according to the load type.
module load_extract
    import wb_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned OW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      ld_sel_i,
    input  logic [OW-1:0]   addr_lo_i,
    output logic [XLEN-1:0] ext_c
);

    logic [XLEN-1:0] sh;

    always_comb begin
        sh    = rdata_i >> {addr_lo_i, 3'b000};
        ext_c = '0;
        case (ld_sel_i)
            LB:      ext_c = XLEN'($signed(sh[7:0]));
            LH:      ext_c = XLEN'($signed(sh[15:0]));
            LW:      ext_c = XLEN'($signed(sh[31:0]));
            LBU:     ext_c = XLEN'(sh[7:0]);
            LHU:     ext_c = XLEN'(sh[15:0]);
            LWU:     ext_c = XLEN'(sh[31:0]);
            LD:      ext_c = sh;
            default: ext_c = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: retires ALU results next cycle, holds loads
// until the data-memory response, and supports flush and misalign reporting.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    parameter  int unsigned NREG = 32,
    localparam int unsigned AW   = $clog2(NREG),
    localparam int unsigned OW   = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [AW-1:0]   wa_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            ld_en_i,
    input  logic [2:0]      ld_sel_i,
    input  logic [OW-1:0]   addr_lo_i,
    input  logic            flush_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_wa_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            misalign_o
);

    state_t          state_q, state_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [2:0]      sel_q, sel_d;
    logic [OW-1:0]   off_q, off_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] ld_data_c;

    load_extract #(.XLEN(XLEN)) u_extract (
        .rdata_i   (dmem_rdata_i),
        .ld_sel_i  (sel_q),
        .addr_lo_i (off_q),
        .ext_c     (ld_data_c)
    );

    always_comb begin
        state_d    = state_q;
        wa_d       = wa_q;
        sel_d      = sel_q;
        off_d      = off_q;
        rf_we_d    = 1'b0;
        rf_wa_d    = rf_wa_q;
        rf_wdata_d = rf_wdata_q;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i && !flush_i) begin
                    if (!ld_en_i) begin
                        rf_we_d    = we_i && (wa_i != '0);
                        rf_wa_d    = wa_i;
                        rf_wdata_d = wdata_i;
                    end else if (!ld_ok(XLEN, ld_sel_i, 3'(addr_lo_i))) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wa_d    = wa_i;
                        sel_d   = ld_sel_i;
                        off_d   = addr_lo_i;
                    end
                end
            end
            WAIT: begin
                // A flush in the response cycle still consumes the response.
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        rf_we_d    = (wa_q != '0);
                        rf_wa_d    = wa_q;
                        rf_wdata_d = ld_data_c;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wa_q       <= '0;
            sel_q      <= '0;
            off_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_wa_q    <= '0;
            rf_wdata_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wa_q       <= wa_d;
            sel_q      <= sel_d;
            off_q      <= off_d;
            rf_we_q    <= rf_we_d;
            rf_wa_q    <= rf_wa_d;
            rf_wdata_q <= rf_wdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign in_ready_o = (state_q == IDLE);
    assign rf_we_o    = rf_we_q;
    assign rf_wa_o    = rf_wa_q;
    assign rf_wdata_o = rf_wdata_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked every cycle against a transaction-level model.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, we, ld_en, flush, rvalid;
    logic [4:0]  wa;
    logic [2:0]  ld_sel, addr_lo;
    logic [63:0] wdata, rdata;

    logic        rdy32, we32, mis32, rdy64, we64, mis64;
    logic [4:0]  wa32, wa64;
    logic [31:0] wd32;
    logic [63:0] wd64;

    int n_vec = 0;
    int n_err = 0;

    // Model: one outstanding-load record per instance and the expected outputs.
    bit          m_pend[2], m_drain[2];
    logic [4:0]  m_wa[2];
    logic [2:0]  m_sel[2];
    int          m_off[2];
    bit          exp_we[2], exp_mis[2], exp_upd[2];
    logic [4:0]  exp_wa[2];
    logic [63:0] exp_wd[2];

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(32), .NREG(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .wa_i(wa), .we_i(we), .wdata_i(wdata[31:0]), .ld_en_i(ld_en),
        .ld_sel_i(ld_sel), .addr_lo_i(addr_lo[1:0]), .flush_i(flush),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0]),
        .rf_we_o(we32), .rf_wa_o(wa32), .rf_wdata_o(wd32), .misalign_o(mis32)
    );

    wb_stage_pipe #(.XLEN(64), .NREG(32)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy64),
        .wa_i(wa), .we_i(we), .wdata_i(wdata), .ld_en_i(ld_en),
        .ld_sel_i(ld_sel), .addr_lo_i(addr_lo), .flush_i(flush),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .rf_we_o(we64), .rf_wa_o(wa64), .rf_wdata_o(wd64), .misalign_o(mis64)
    );

    function automatic bit legal(input int xl, input logic [2:0] sel, input int off);
        int nb;
        if (sel == 3'd7) return 1'b0;
        if (xl == 32 && (sel == 3'd3 || sel == 3'd6)) return 1'b0;
        nb = 1 << sel[1:0];
        return (off % nb) == 0;
    endfunction

    function automatic logic [63:0] extract(input int xl, input logic [63:0] rd,
                                            input logic [2:0] sel, input int off);
        int nb;
        logic [63:0] mask, v;
        nb   = 1 << sel[1:0];
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = (rd >> (8 * off)) & mask;
        if (!sel[2] && v[8 * nb - 1]) v = v | ~mask;
        if (xl == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 0; m_drain[m] = 0;
            exp_we[m] = 0; exp_mis[m] = 0; exp_upd[m] = 0;
        end
    endtask

    task automatic model_step(input int m);
        int xl, off;
        logic [63:0] rd, wd;
        xl  = (m == 0) ? 32 : 64;
        off = (m == 0) ? int'(addr_lo[1:0]) : int'(addr_lo);
        rd  = (m == 0) ? {32'd0, rdata[31:0]} : rdata;
        wd  = (m == 0) ? {32'd0, wdata[31:0]} : wdata;
        exp_we[m] = 0; exp_mis[m] = 0; exp_upd[m] = 0;
        if (!m_pend[m]) begin
            if (in_valid && !flush) begin
                if (!ld_en) begin
                    if (we) begin
                        exp_upd[m] = 1; exp_we[m] = (wa != 0);
                        exp_wa[m] = wa; exp_wd[m] = wd;
                    end
                end else if (!legal(xl, ld_sel, off)) begin
                    exp_mis[m] = 1;
                end else begin
                    m_pend[m] = 1; m_drain[m] = 0;
                    m_wa[m] = wa; m_sel[m] = ld_sel; m_off[m] = off;
                end
            end
        end else if (m_drain[m]) begin
            if (rvalid) m_pend[m] = 0;
        end else if (rvalid) begin
            m_pend[m] = 0;
            if (!flush) begin
                exp_upd[m] = 1; exp_we[m] = (m_wa[m] != 0);
                exp_wa[m] = m_wa[m];
                exp_wd[m] = extract(xl, rd, m_sel[m], m_off[m]);
            end
        end else if (flush) begin
            m_drain[m] = 1;
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        chk("ready32", 64'(rdy32), 64'(!m_pend[0]));
        chk("ready64", 64'(rdy64), 64'(!m_pend[1]));
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        chk("we32", 64'(we32), 64'(exp_we[0]));
        chk("mis32", 64'(mis32), 64'(exp_mis[0]));
        chk("we64", 64'(we64), 64'(exp_we[1]));
        chk("mis64", 64'(mis64), 64'(exp_mis[1]));
        if (exp_upd[0]) begin
            chk("wa32", 64'(wa32), 64'(exp_wa[0]));
            chk("wdata32", 64'(wd32), exp_wd[0]);
        end
        if (exp_upd[1]) begin
            chk("wa64", 64'(wa64), 64'(exp_wa[1]));
            chk("wdata64", wd64, exp_wd[1]);
        end
    endtask

    task automatic clr();
        in_valid = 0; we = 0; ld_en = 0; flush = 0; rvalid = 0;
        wa = 0; ld_sel = 0; addr_lo = 0; wdata = 0; rdata = 0;
    endtask

    task automatic load(input logic [2:0] sel, input logic [2:0] off, input logic [4:0] a);
        clr();
        in_valid = 1; ld_en = 1; ld_sel = sel; addr_lo = off; wa = a;
    endtask

    initial begin
        clr();
        rst = 1;
        model_reset();
        #1;
        chk("rst_ready32", 64'(rdy32), 64'd1);
        chk("rst_we32", 64'(we32), 64'd0);
        chk("rst_wdata64", wd64, 64'd0);
        chk("rst_mis64", 64'(mis64), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // ALU write
        clr(); in_valid = 1; we = 1; wa = 5; wdata = 64'hDEADBEEF;
        tick();
        chk("alu_we", 64'(we32), 64'd1);
        chk("alu_wa", 64'(wa32), 64'd5);
        chk("alu_wdata", 64'(wd32), 64'hDEADBEEF);
        chk("alu_ready", 64'(rdy32), 64'd1);

        // LB / LBU at offset 2, response three cycles after acceptance
        for (int s = 0; s < 2; s++) begin
            load((s == 0) ? 3'b000 : 3'b100, 3'd2, 5'd7);
            tick();
            clr();
            chk("lb_ready_low", 64'(rdy32), 64'd0);
            tick(); tick();
            rvalid = 1; rdata = 64'h12F45678;
            tick();
            clr();
            chk("lb_we", 64'(we32), 64'd1);
            chk("lb_wdata", 64'(wd32), (s == 0) ? 64'hFFFFFFF4 : 64'h000000F4);
            chk("lb_ready_back", 64'(rdy32), 64'd1);
        end

        // Misaligned LH
        load(3'b001, 3'd1, 5'd4);
        tick();
        clr();
        chk("lh_mis", 64'(mis32), 64'd1);
        chk("lh_no_we", 64'(we32), 64'd0);
        tick();
        chk("lh_mis_once", 64'(mis32), 64'd0);

        // Flush while waiting, response arrives later and is drained
        load(3'b010, 3'd0, 5'd3);
        tick();
        clr(); flush = 1;
        tick();
        clr();
        tick();
        rvalid = 1; rdata = 64'hAAAAAAAA;
        tick();
        clr();
        chk("drain_no_we", 64'(we32), 64'd0);
        chk("drain_ready", 64'(rdy32), 64'd1);

        // Flush and response in the same cycle
        load(3'b010, 3'd0, 5'd3);
        tick();
        clr(); flush = 1; rvalid = 1; rdata = 64'h55555555;
        tick();
        clr();
        chk("flushrv_no_we", 64'(we32), 64'd0);
        chk("flushrv_ready", 64'(rdy32), 64'd1);

        // XLEN=64: LWU at offset 4
        load(3'b110, 3'd4, 5'd10);
        tick();
        clr(); rvalid = 1; rdata = 64'h80000001_00000000;
        tick();
        clr();
        chk("lwu_wdata64", wd64, 64'h0000000080000001);
        chk("lwu_we64", 64'(we64), 64'd1);

        // XLEN=64: LD to x0 updates data but never strobes
        load(3'b011, 3'd0, 5'd0);
        tick();
        clr(); rvalid = 1; rdata = 64'h0123456789ABCDEF;
        tick();
        clr();
        chk("ldx0_we64", 64'(we64), 64'd0);
        chk("ldx0_wdata64", wd64, 64'h0123456789ABCDEF);

        // Reset in the middle of a load; later response is spurious
        load(3'b010, 3'd0, 5'd6);
        tick();
        clr();
        chk("mid_ready_low", 64'(rdy64), 64'd0);
        #2 rst = 1;
        #1;
        chk("mid_rst_ready", 64'(rdy64), 64'd1);
        chk("mid_rst_wdata", 64'(wd32), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        rvalid = 1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        clr();
        chk("spurious_no_we", 64'(we64), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            we       = ($urandom_range(0, 3) != 0);
            ld_en    = ($urandom_range(0, 1) == 1);
            ld_sel   = 3'($urandom_range(0, 7));
            addr_lo  = 3'($urandom_range(0, 7));
            wa       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            flush    = ($urandom_range(0, 9) == 0);
            rvalid   = ($urandom_range(0, 2) == 0);
            wdata    = {$urandom, $urandom};
            rdata    = {$urandom, $urandom};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
